// File: rtl/mini_src_pkg.sv
// Shared definitions for the Mini SRC control unit: opcodes, ALU operation
// codes, bus source selects, fault codes, instruction classes and the
// sequencer state encoding.
package mini_src_pkg;

  // Opcodes (IR[31:27])
  localparam logic [4:0] OpAdd  = 5'b00000;
  localparam logic [4:0] OpSub  = 5'b00001;
  localparam logic [4:0] OpAnd  = 5'b00010;
  localparam logic [4:0] OpOr   = 5'b00011;
  localparam logic [4:0] OpShr  = 5'b00100;
  localparam logic [4:0] OpShl  = 5'b00101;
  localparam logic [4:0] OpRor  = 5'b00110;
  localparam logic [4:0] OpRol  = 5'b00111;
  localparam logic [4:0] OpMul  = 5'b01000;
  localparam logic [4:0] OpDiv  = 5'b01001;
  localparam logic [4:0] OpNeg  = 5'b01010;
  localparam logic [4:0] OpNot  = 5'b01011;
  localparam logic [4:0] OpHalt = 5'b11011;

  // ALU operation codes
  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluSub = 4'b0001;
  localparam logic [3:0] AluNeg = 4'b0010;
  localparam logic [3:0] AluNot = 4'b0011;
  localparam logic [3:0] AluAnd = 4'b0100;
  localparam logic [3:0] AluOr  = 4'b0101;
  localparam logic [3:0] AluShr = 4'b0110;
  localparam logic [3:0] AluShl = 4'b0111;
  localparam logic [3:0] AluRor = 4'b1000;
  localparam logic [3:0] AluRol = 4'b1001;
  localparam logic [3:0] AluMul = 4'b1010;
  localparam logic [3:0] AluDiv = 4'b1011;

  // Bus source selects; 0xxxx addresses GP register xxxx
  localparam logic [4:0] BusHi    = 5'b10000;
  localparam logic [4:0] BusLo    = 5'b10001;
  localparam logic [4:0] BusZhigh = 5'b10010;
  localparam logic [4:0] BusZlow  = 5'b10011;
  localparam logic [4:0] BusPc    = 5'b10100;
  localparam logic [4:0] BusMdr   = 5'b10101;

  // Halt cause, reported while halted
  localparam logic [1:0] FaultNone       = 2'b00;
  localparam logic [1:0] FaultIllegal    = 2'b01;
  localparam logic [1:0] FaultMemTimeout = 2'b10;

  typedef enum logic [2:0] {
    ClsBinary,   // two-source ALU op, result to Ra
    ClsUnary,    // NEG/NOT, Rb -> Ra
    ClsMulDiv,   // 64-bit result to HI/LO
    ClsHalt,
    ClsIllegal
  } instr_class_e;

  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  function automatic logic [4:0] gp_sel(input logic [3:0] r);
    return {1'b0, r};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational opcode decoder for the Mini SRC control unit.
// Ports:
//   op        in  5  opcode field IR[31:27]
//   op_class  out    instruction class (binary/unary/muldiv/halt/illegal)
//   alu_op    out 4  ALU operation for the execute step (0000 when unused)
//   legal     out 1  opcode is one the sequencer knows (HALT included)
module instr_decoder
  import mini_src_pkg::*;
(
  input  logic [4:0]   op,
  output instr_class_e op_class,
  output logic [3:0]   alu_op,
  output logic         legal
);

  always_comb begin
    op_class = ClsIllegal;
    alu_op   = AluAdd;
    legal    = 1'b1;
    case (op)
      OpAdd:  begin op_class = ClsBinary; alu_op = AluAdd; end
      OpSub:  begin op_class = ClsBinary; alu_op = AluSub; end
      OpAnd:  begin op_class = ClsBinary; alu_op = AluAnd; end
      OpOr:   begin op_class = ClsBinary; alu_op = AluOr;  end
      OpShr:  begin op_class = ClsBinary; alu_op = AluShr; end
      OpShl:  begin op_class = ClsBinary; alu_op = AluShl; end
      OpRor:  begin op_class = ClsBinary; alu_op = AluRor; end
      OpRol:  begin op_class = ClsBinary; alu_op = AluRol; end
      OpMul:  begin op_class = ClsMulDiv; alu_op = AluMul; end
      OpDiv:  begin op_class = ClsMulDiv; alu_op = AluDiv; end
      OpNeg:  begin op_class = ClsUnary;  alu_op = AluNeg; end
      OpNot:  begin op_class = ClsUnary;  alu_op = AluNot; end
      OpHalt: op_class = ClsHalt;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit for the Mini SRC datapath. A Moore FSM steps
// through fetch (T0-T2) and execute (T3-T6), driving the datapath enables,
// bus source select, GP write address and ALU operation for one clock per
// step. Fetch waits on mem_ready; the unit halts on HALT, an illegal opcode
// or a memory timeout, and leaves HALT only through clear.
// Ports:
//   clock          in   system clock, rising edge
//   clear          in   synchronous active-high reset
//   run            in   start request, sampled only in IDLE
//   mem_ready      in   Mdatain valid this cycle
//   IR             in   instruction register contents
//   e_PC..e_GP     out  register load enables
//   incPC          out  Z <= PC+1 path select
//   MDR_read       out  MDR loads from Mdatain
//   BusDataSelect  out  bus source select
//   GP_addr        out  GP register write address
//   ALU_op         out  ALU operation
//   instr_done     out  pulse on the last step of an instruction
//   halted         out  high in HALT
//   fault          out  halt cause (00 none, 01 illegal, 10 memory timeout)
module control_sequencer
  import mini_src_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] IR,
  output logic              e_PC,
  output logic              e_IR,
  output logic              e_Y,
  output logic              e_Z,
  output logic              e_HI,
  output logic              e_LO,
  output logic              e_MDR,
  output logic              e_MAR,
  output logic              e_GP,
  output logic              incPC,
  output logic              MDR_read,
  output logic [4:0]        BusDataSelect,
  output logic [3:0]        GP_addr,
  output logic [3:0]        ALU_op,
  output logic              instr_done,
  output logic              halted,
  output logic [1:0]        fault
);

  localparam int unsigned CntW = $clog2(MEM_WAIT_MAX + 1);

  state_e          state_q;
  logic [CntW-1:0] wait_cnt_q;
  logic [1:0]      fault_q;

  logic [4:0]   op;
  logic [3:0]   ra, rb, rc;
  instr_class_e op_class;
  logic [3:0]   dec_alu_op;
  logic         dec_legal;

  assign op = IR[31:27];
  assign ra = IR[26:23];
  assign rb = IR[22:19];
  assign rc = IR[18:15];

  logic unused_ir;
  assign unused_ir = ^IR[14:0];

  instr_decoder u_instr_decoder (
    .op       (op),
    .op_class (op_class),
    .alu_op   (dec_alu_op),
    .legal    (dec_legal)
  );

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
      fault_q    <= FaultNone;
    end else begin
      unique case (state_q)
        StIdle: if (run) state_q <= StT0;
        StT0: begin
          state_q    <= StT1;
          wait_cnt_q <= '0;
        end
        StT1: begin
          // A ready on the last allowed cycle still completes the fetch.
          if (mem_ready) begin
            state_q <= StT2;
          end else if (wait_cnt_q == CntW'(MEM_WAIT_MAX - 1)) begin
            state_q <= StHalt;
            fault_q <= FaultMemTimeout;
          end else begin
            wait_cnt_q <= wait_cnt_q + CntW'(1);
          end
        end
        StT2: state_q <= StT3;
        StT3: begin
          if (op_class == ClsHalt) begin
            state_q <= StHalt;
            fault_q <= FaultNone;
          end else if (!dec_legal) begin
            state_q <= StHalt;
            fault_q <= FaultIllegal;
          end else begin
            state_q <= StT4;
          end
        end
        StT4: state_q <= StT5;
        StT5: state_q <= (op_class == ClsMulDiv) ? StT6 : StT0;
        StT6: state_q <= StT0;
        StHalt: state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode from the state register; only the T1 fetch-complete
  // signals (e_PC and the Zlow select) also look at mem_ready.
  always_comb begin
    e_PC          = 1'b0;
    e_IR          = 1'b0;
    e_Y           = 1'b0;
    e_Z           = 1'b0;
    e_HI          = 1'b0;
    e_LO          = 1'b0;
    e_MDR         = 1'b0;
    e_MAR         = 1'b0;
    e_GP          = 1'b0;
    incPC         = 1'b0;
    MDR_read      = 1'b0;
    BusDataSelect = 5'b00000;
    GP_addr       = 4'b0000;
    ALU_op        = 4'b0000;
    instr_done    = 1'b0;
    halted        = 1'b0;
    unique case (state_q)
      StT0: begin
        BusDataSelect = BusPc;
        e_MAR         = 1'b1;
        incPC         = 1'b1;
        e_Z           = 1'b1;
      end
      StT1: begin
        MDR_read = 1'b1;
        e_MDR    = 1'b1;
        if (mem_ready) begin
          BusDataSelect = BusZlow;
          e_PC          = 1'b1;
        end
      end
      StT2: begin
        BusDataSelect = BusMdr;
        e_IR          = 1'b1;
      end
      StT3: begin
        unique case (op_class)
          ClsBinary, ClsUnary: begin
            BusDataSelect = gp_sel(rb);
            e_Y           = 1'b1;
          end
          ClsMulDiv: begin
            BusDataSelect = gp_sel(ra);
            e_Y           = 1'b1;
          end
          default: ;
        endcase
      end
      StT4: begin
        e_Z           = 1'b1;
        ALU_op        = dec_alu_op;
        BusDataSelect = (op_class == ClsBinary) ? gp_sel(rc) : gp_sel(rb);
      end
      StT5: begin
        BusDataSelect = BusZlow;
        if (op_class == ClsMulDiv) begin
          e_LO = 1'b1;
        end else begin
          GP_addr    = ra;
          e_GP       = 1'b1;
          instr_done = 1'b1;
        end
      end
      StT6: begin
        BusDataSelect = BusZhigh;
        e_HI          = 1'b1;
        instr_done    = 1'b1;
      end
      StHalt: halted = 1'b1;
      default: ;
    endcase
  end

  assign fault = fault_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer. A driver issues instructions with
// randomized registers, opcodes and memory wait lengths and, cycle by cycle,
// queues the output vector the control-step rules predict. A monitor pops and
// compares the queue on every falling edge.
module tb_control_sequencer;

  localparam int WaitMax = 15;

  localparam logic [4:0] SelHi    = 5'b10000;
  localparam logic [4:0] SelLo    = 5'b10001;
  localparam logic [4:0] SelZhigh = 5'b10010;
  localparam logic [4:0] SelZlow  = 5'b10011;
  localparam logic [4:0] SelPc    = 5'b10100;
  localparam logic [4:0] SelMdr   = 5'b10101;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] IR;
  logic        e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read;
  logic [4:0]  BusDataSelect;
  logic [3:0]  GP_addr, ALU_op;
  logic        instr_done, halted;
  logic [1:0]  fault;

  typedef struct packed {
    logic       e_pc, e_ir, e_y, e_z, e_hi, e_lo, e_mdr, e_mar, e_gp, inc_pc, mdr_read;
    logic [4:0] sel;
    logic [3:0] gp;
    logic [3:0] alu;
    logic       done;
    logic       halted;
    logic [1:0] fault;
  } out_t;

  out_t act;
  assign act = {e_PC, e_IR, e_Y, e_Z, e_HI, e_LO, e_MDR, e_MAR, e_GP, incPC, MDR_read,
                BusDataSelect, GP_addr, ALU_op, instr_done, halted, fault};

  out_t  exp_q[$];
  string tag_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  // ALU code for opcodes 0..11, in opcode order
  int alu_map[12] = '{0, 1, 4, 5, 6, 7, 8, 9, 10, 11, 2, 3};

  control_sequencer #(
    .MEM_WAIT_MAX (WaitMax),
    .DATA_W       (32)
  ) dut (
    .clock         (clock),
    .clear         (clear),
    .run           (run),
    .mem_ready     (mem_ready),
    .IR            (IR),
    .e_PC          (e_PC),
    .e_IR          (e_IR),
    .e_Y           (e_Y),
    .e_Z           (e_Z),
    .e_HI          (e_HI),
    .e_LO          (e_LO),
    .e_MDR         (e_MDR),
    .e_MAR         (e_MAR),
    .e_GP          (e_GP),
    .incPC         (incPC),
    .MDR_read      (MDR_read),
    .BusDataSelect (BusDataSelect),
    .GP_addr       (GP_addr),
    .ALU_op        (ALU_op),
    .instr_done    (instr_done),
    .halted        (halted),
    .fault         (fault)
  );

  always #5 clock = ~clock;

  // Monitor
  out_t  mon_e;
  string mon_t;
  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        mon_t = tag_q.pop_front();
        n_tests++;
        if (act !== mon_e) begin
          n_fail++;
          $display("FAIL %s @%0t: got sel=%b gp=%h alu=%h vec=%h, want sel=%b gp=%h alu=%h vec=%h",
                   mon_t, $time, act.sel, act.gp, act.alu, act, mon_e.sel, mon_e.gp,
                   mon_e.alu, mon_e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input out_t e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    @(posedge clock);
    #1;
  endtask

  function automatic out_t o_zero();
    out_t e;
    e = '0;
    return e;
  endfunction

  function automatic out_t o_halt(input logic [1:0] f);
    out_t e;
    e = '0;
    e.halted = 1'b1;
    e.fault  = f;
    return e;
  endfunction

  // Sit in HALT a few cycles (run must not matter), then clear back to IDLE.
  task automatic halt_seq(input logic [1:0] f);
    for (int k = 0; k < 3; k++) begin
      run = 1'($urandom);
      cyc(o_halt(f), "halt");
    end
    clear = 1'b1;
    cyc(o_halt(f), "halt_clear_cycle");
    clear = 1'b0;
    run   = 1'b0;
    cyc(o_zero(), "idle_after_clear");
  endtask

  task automatic start_run();
    run = 1'b1;
    cyc(o_zero(), "idle_run");
    run = 1'b0;
  endtask

  // Drive one instruction from T0. waits = T1 cycles with mem_ready low before
  // it rises (>= WaitMax means never). stopped=1 when the DUT ended up in IDLE.
  task automatic run_instr(input logic [31:0] ir, input int waits, input bit clr_t4,
                           output bit stopped);
    int   op, ra, rb, rc;
    bit   got;
    out_t e;
    op = int'(ir[31:27]);
    ra = int'(ir[26:23]);
    rb = int'(ir[22:19]);
    rc = int'(ir[18:15]);
    stopped = 1'b0;
    IR  = ir;
    run = 1'($urandom);

    e = '0; e.sel = SelPc; e.e_mar = 1; e.inc_pc = 1; e.e_z = 1;
    cyc(e, "T0");

    got = 1'b0;
    for (int i = 0; i < WaitMax && !got; i++) begin
      mem_ready = (i == waits);
      got = mem_ready;
      e = '0; e.mdr_read = 1; e.e_mdr = 1;
      if (got) begin e.sel = SelZlow; e.e_pc = 1; end
      cyc(e, got ? "T1_ready" : "T1_wait");
    end
    mem_ready = 1'b0;
    if (!got) begin
      halt_seq(2'b10);
      stopped = 1'b1;
      return;
    end

    e = '0; e.sel = SelMdr; e.e_ir = 1;
    cyc(e, "T2");

    if (op > 11) begin
      cyc(o_zero(), "T3_stop");
      halt_seq((op == 27) ? 2'b00 : 2'b01);
      stopped = 1'b1;
      return;
    end

    e = '0; e.e_y = 1;
    e.sel = (op == 8 || op == 9) ? 5'(ra) : 5'(rb);
    cyc(e, "T3");

    e = '0; e.e_z = 1; e.alu = 4'(alu_map[op]);
    e.sel = (op <= 7) ? 5'(rc) : 5'(rb);
    if (clr_t4) begin
      clear = 1'b1;
      cyc(e, "T4_clear");
      clear = 1'b0;
      run   = 1'b0;
      cyc(o_zero(), "idle_after_t4_clear");
      stopped = 1'b1;
      return;
    end
    cyc(e, "T4");

    e = '0; e.sel = SelZlow;
    if (op == 8 || op == 9) begin
      e.e_lo = 1;
      cyc(e, "T5_lo");
      e = '0; e.sel = SelZhigh; e.e_hi = 1; e.done = 1;
      cyc(e, "T6");
    end else begin
      e.gp = 4'(ra); e.e_gp = 1; e.done = 1;
      cyc(e, "T5_gp");
    end
  endtask

  initial begin
    bit          stopped;
    logic [31:0] ir;
    int          op;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = '0;
    @(posedge clock); #1;
    cyc(o_zero(), "reset");
    clear = 1'b0;
    cyc(o_zero(), "idle_no_run");
    cyc(o_zero(), "idle_no_run");
    start_run();

    run_instr(32'h0189_0000, 0, 1'b0, stopped);        // ADD R3,R1,R2
    run_instr(32'h5280_0000, 0, 1'b0, stopped);        // NEG R5,R0
    run_instr(32'h4338_0000, 0, 1'b0, stopped);        // MUL R6,R7
    run_instr(32'h0189_0000, 3, 1'b0, stopped);        // 3-cycle memory wait
    run_instr(32'h0189_0000, WaitMax - 1, 1'b0, stopped); // ready on the limit cycle

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) == 0) op = $urandom_range(12, 31);
      else op = $urandom_range(0, 11);
      ir = {5'(op), 27'($urandom)};
      run_instr(ir, $urandom_range(0, 4), 1'b0, stopped);
      if (stopped) start_run();
    end

    run_instr(32'h0189_0000, WaitMax, 1'b0, stopped);  // memory timeout
    start_run();
    run_instr(32'hF800_0000, 0, 1'b0, stopped);        // illegal opcode
    start_run();
    run_instr(32'hD800_0000, 0, 1'b0, stopped);        // HALT
    start_run();
    run_instr(32'h0189_0000, 1, 1'b1, stopped);        // clear during T4
    start_run();
    run_instr(32'h0189_0000, 0, 1'b0, stopped);

    @(negedge clock);
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
